// File: rtl/uart_wb_pkg.sv
// rtl/uart_wb_pkg.sv - shared state enum, register map and helpers for uart_wb_master
package uart_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    RX_RD,
    TX_WR,
    GAP
  } state_t;

  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;

  localparam int STATUS_RX_READY = 0;
  localparam int STATUS_TX_IDLE  = 5;

  // A zero-gap build still needs a one-bit counter to hold the single GAP cycle.
  function automatic int gap_width(input int poll_gap);
    return (poll_gap > 0) ? $clog2(poll_gap + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_slot.sv
// rtl/uart_byte_slot.sv - one-entry valid/data byte holding register
module uart_byte_slot (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       clear,
  output logic       valid,
  output logic [7:0] data
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid <= 1'b0;
      data  <= 8'h00;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - Wishbone initiator polling a UART controller for RX/TX bytes
// Optional watchdog on stalled accesses enabled by defining UART_WB_TIMEOUT_EN.
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int                    POLL_GAP   = 4,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  input  logic                    tx_valid_i,
  input  logic [7:0]              tx_data_i,
  output logic                    tx_ready_o,
  output logic                    rx_valid_o,
  output logic [7:0]              rx_data_o,
  input  logic                    rx_ready_i,
  output logic                    err_o
);

  localparam logic [ADDR_WIDTH-1:0] ADR_STATUS = BASE_ADDR + ADDR_WIDTH'(REG_STATUS);
  localparam logic [ADDR_WIDTH-1:0] ADR_DATA   = BASE_ADDR + ADDR_WIDTH'(REG_DATA);
  localparam logic [DATA_WIDTH/8-1:0] SEL_BYTE0 = (DATA_WIDTH/8)'(1);
  localparam int GAP_W = gap_width(POLL_GAP);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(POLL_GAP);

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             tx_full;
  logic [7:0]       tx_byte;
  logic             tx_load;
  logic             tx_drain;
  logic             rx_load;
  logic             rx_clear;
  logic             wd_hit;
  logic             unused_dat;

  assign unused_dat = ^wb_dat_i[DATA_WIDTH-1:8];

  assign tx_load  = tx_valid_i && tx_ready_o;
  assign tx_drain = (state == TX_WR) && wb_stb_o && wb_ack_i;
  assign rx_load  = (state == RX_RD) && wb_stb_o && wb_ack_i;
  assign rx_clear = rx_valid_o && rx_ready_i;

  uart_byte_slot u_tx_slot (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load      (tx_load),
    .load_data (tx_data_i),
    .clear     (tx_drain),
    .valid     (tx_full),
    .data      (tx_byte)
  );

  uart_byte_slot u_rx_slot (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load      (rx_load),
    .load_data (wb_dat_i[7:0]),
    .clear     (rx_clear),
    .valid     (rx_valid_o),
    .data      (rx_data_o)
  );

  // Ready follows the slot's next fill state, so a drained slot only reopens one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_ready_o <= 1'b0;
    end else begin
      tx_ready_o <= !((tx_full && !tx_drain) || tx_load);
    end
  end

`ifdef UART_WB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_hit = wb_stb_o && !wb_ack_i && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wd_hit;
      if (!wb_stb_o || wb_ack_i || wd_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end
`else
  assign wd_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_adr_o <= ADR_STATUS;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
    end else if (wd_hit) begin
      // Abandon the stalled access; slot contents are left as they were.
      state    <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_valid_o || tx_full) begin
            state    <= POLL;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_adr_o <= ADR_STATUS;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
          end
        end
        POLL: begin
          if (wb_stb_o && wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (wb_dat_i[STATUS_RX_READY] && !rx_valid_o) begin
              state <= RX_RD;
            end else if (wb_dat_i[STATUS_TX_IDLE] && tx_full) begin
              state <= TX_WR;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_W'(1);
            end
          end
        end
        RX_RD: begin
          if (!wb_stb_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_adr_o <= ADR_DATA;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
          end else if (wb_ack_i) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
          end
        end
        TX_WR: begin
          if (!wb_stb_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_adr_o <= ADR_DATA;
            wb_we_o  <= 1'b1;
            wb_sel_o <= SEL_BYTE0;
            wb_dat_o <= DATA_WIDTH'(tx_byte);
          end else if (wb_ack_i) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_MAX) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h1000_0000, UART controller base address.
REQ-004 The block SHALL have parameter POLL_GAP, default 4, idle cycles between unproductive status polls (0 allowed).
REQ-005 The block SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
clk_i  in  1  sole clock, all state on rising edge
rst_ni  in  1  asynchronous, active-low reset
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_ack_i  in  1  slave acknowledge
wb_adr_o  out  ADDR_WIDTH  address
wb_dat_o  out  DATA_WIDTH  write data
wb_dat_i  in  DATA_WIDTH  read data
wb_sel_o  out  DATA_WIDTH/8  byte select
wb_we_o  out  1  write enable
tx_valid_i  in  1  byte to send offered
tx_data_i  in  8  byte to send
tx_ready_o  out  1  TX slot empty
rx_valid_o  out  1  received byte available
rx_data_o  out  8  received byte
rx_ready_i  in  1  consumer takes byte
err_o  out  1  one-cycle timeout pulse

Function
REQ-007 The block SHALL be a Wishbone initiator driving the UART controller: STATUS at BASE_ADDR+0x04 (bit0 rx data ready, bit5 tx idle), DATA at BASE_ADDR+0x00.
REQ-008 Every access SHALL assert cyc and stb together, hold address, we, sel and data stable until the ack cycle, and deassert both on the clock edge after ack.
REQ-009 wb_sel_o SHALL be 4'b0001 and wb_dat_o SHALL be {24'b0, byte} on writes and all zero on reads.
REQ-010 The FSM SHALL have these states: IDLE, POLL, RX_RD, TX_WR, GAP.
REQ-011 IDLE SHALL go to POLL when the RX slot is empty or the TX slot is full, and stay in IDLE otherwise.
REQ-012 On a POLL ack, the FSM SHALL go to RX_RD if status bit0=1 and the RX slot is empty; else to TX_WR if status bit5=1 and the TX slot is full; else to GAP.
REQ-013 RX is given priority over TX so the receiver never overruns while TX waits.
REQ-014 On an RX_RD ack, the block SHALL load wb_dat_i[7:0] into the RX slot, set rx_valid_o next cycle, and return to IDLE.
REQ-015 On a TX_WR ack, the block SHALL empty the TX slot (tx_ready_o=1 next cycle) and return to IDLE.
REQ-016 GAP SHALL count POLL_GAP cycles and then go to IDLE; POLL_GAP=0 SHALL mean GAP lasts exactly one cycle.
REQ-017 The TX slot SHALL load on tx_valid_i && tx_ready_o; tx_ready_o SHALL be registered, with no same-cycle bypass from drain to refill.
REQ-018 The RX slot SHALL hold rx_data_o stable while rx_valid_o=1 until rx_ready_i; it SHALL clear on rx_valid_o && rx_ready_i.
REQ-019 A byte SHALL never be overwritten: RX_RD is entered only when the RX slot is empty.
REQ-020 The gap counter width SHALL be $clog2(POLL_GAP+1); the counter SHALL not wrap.

Reset
REQ-021 While rst_ni=0 all outputs SHALL be 0 (combinationally through the async clear), except wb_adr_o=BASE_ADDR+0x04.
REQ-022 Reset SHALL return the FSM to IDLE and empty both slots.
REQ-023 Reset asserted mid-access SHALL drop cyc and stb immediately; the in-flight byte SHALL be discarded.
REQ-024 tx_ready_o SHALL rise on the first clock edge after reset release.

Configuration
REQ-025 With UART_WB_TIMEOUT_EN defined, a watchdog SHALL count cycles with stb=1 and ack=0.
REQ-026 When the watchdog count reaches TIMEOUT, the block SHALL drop cyc and stb, pulse err_o for one cycle, keep both slots unchanged, and go to IDLE.
REQ-027 Without UART_WB_TIMEOUT_EN, there SHALL be no watchdog, err_o SHALL be tied 0, and the block SHALL wait for ack indefinitely.

Structure
REQ-028 Package uart_wb_pkg SHALL hold the state enum, REG_DATA=8'h00, REG_STATUS=8'h04, STATUS_RX_READY=0 and STATUS_TX_IDLE=5.
REQ-029 The one-entry valid/data holding register SHALL be sub-module uart_byte_slot, instantiated twice (TX and RX).

Verification
REQ-030 TX write: reset, then tx byte 0x41 with a status model returning 0x20 -> one POLL read at 0x04, then one write at 0x00 with dat=0x00000041 and sel=0001; tx_ready_o low then high.
REQ-031 RX read: status model returns 0x21 with data 0x5A and rx_ready_i=0 -> RX_RD read; rx_valid_o=1 and rx_data_o=0x5A held stable; no further RX_RD until rx_ready_i pulses.
REQ-032 Priority: TX slot full and status returns 0x21 -> RX_RD precedes TX_WR.
REQ-033 Gap: status returns 0x00 with POLL_GAP=4 -> consecutive POLL strobes are spaced by ack + 4 GAP cycles + IDLE.
REQ-034 Timeout (macro on, TIMEOUT=8, slave never acks) -> stb drops after 8 cycles, err_o pulses once, TX slot is preserved; with the macro off, err_o stays 0.
REQ-035 Reset mid-TX_WR -> cyc and stb fall without waiting for a clock edge; after release, tx_ready_o=1 and rx_valid_o=0.
